unbiased_rounding: RTL and testbench

//  Registered width reducer for datapath words. Drops the WIDTH_IN-WIDTH_OUT LSBs
//  of din using round-half-to-even (convergent) rounding, then saturates to the

---
 rtl/unbiased_rounding.sv | 76 +++++++
 tb/tb_unbiased_rounding.sv | 133 +++++++++++++
 2 files changed

// File: rtl/unbiased_rounding.sv
// Registered width reducer: convergent (round-half-to-even) rounding of the dropped
// LSBs followed by saturation to the output range, for signed or unsigned words.
module unbiased_rounding #(
    parameter int unsigned WIDTH_IN  = 32,
    parameter int unsigned WIDTH_OUT = 16,
    parameter bit          IS_SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH_IN-1:0]  din,
    output logic [WIDTH_OUT-1:0] dout
);

    localparam int unsigned D = WIDTH_IN - WIDTH_OUT;

    logic [WIDTH_OUT-1:0] rounded;

    generate
        if (D == 0) begin : g_passthrough
            always_comb begin
                rounded = din;
            end
        end else begin : g_round
            logic [WIDTH_OUT-1:0] keep;
            logic                 guard;
            logic                 sticky;
            logic                 round_up;
            logic [WIDTH_OUT:0]   keep_ext;
            logic [WIDTH_OUT:0]   sum;

            assign keep  = din[WIDTH_IN-1:D];
            assign guard = din[D-1];

            if (D >= 2) begin : g_sticky
                assign sticky = |din[D-2:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end

            // Exact halves only round up when that lands on an even result.
            assign round_up = guard & (sticky | keep[0]);

            if (IS_SIGNED) begin : g_sext
                assign keep_ext = {keep[WIDTH_OUT-1], keep};
            end else begin : g_zext
                assign keep_ext = {1'b0, keep};
            end

            assign sum = keep_ext + {{WIDTH_OUT{1'b0}}, round_up};

            always_comb begin
                rounded = sum[WIDTH_OUT-1:0];
                if (IS_SIGNED) begin
                    // The two top bits disagree only when the result left the signed range.
                    if (!sum[WIDTH_OUT] && sum[WIDTH_OUT-1]) begin
                        rounded = {1'b0, {(WIDTH_OUT-1){1'b1}}};
                    end else if (sum[WIDTH_OUT] && !sum[WIDTH_OUT-1]) begin
                        rounded = {1'b1, {(WIDTH_OUT-1){1'b0}}};
                    end
                end else if (sum[WIDTH_OUT]) begin
                    rounded = {WIDTH_OUT{1'b1}};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (ena) begin
            dout <= rounded;
        end
    end

endmodule

// File: tb/tb_unbiased_rounding.sv
// Directed and sweep checks of unbiased_rounding (32->16) for signed and unsigned
// builds against hand values and an integer round-half-to-even model.
module tb_unbiased_rounding;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [31:0] din;
    logic [15:0] dout_s;
    logic [15:0] dout_u;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    unbiased_rounding #(.WIDTH_IN(32), .WIDTH_OUT(16), .IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .dout(dout_s)
    );

    unbiased_rounding #(.WIDTH_IN(32), .WIDTH_OUT(16), .IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .dout(dout_u)
    );

    typedef struct {
        logic [31:0] x;
        logic [15:0] exp_s;
        logic [15:0] exp_u;
    } vec_t;

    vec_t table_v[13] = '{
        '{32'h0001_8000, 16'h0002, 16'h0002},
        '{32'h0002_8000, 16'h0002, 16'h0002},
        '{32'hFFFF_8000, 16'h0000, 16'hFFFF},
        '{32'hFFFE_8000, 16'hFFFE, 16'hFFFE},
        '{32'h0002_8001, 16'h0003, 16'h0003},
        '{32'h0002_7FFF, 16'h0002, 16'h0002},
        '{32'hFFFF_C000, 16'h0000, 16'hFFFF},
        '{32'hFFFF_4000, 16'hFFFF, 16'hFFFF},
        '{32'h7FFF_8000, 16'h7FFF, 16'h8000},
        '{32'h8000_0000, 16'h8000, 16'h8000},
        '{32'hFFFF_FFFF, 16'h0000, 16'hFFFF},
        '{32'h0000_8000, 16'h0000, 16'h0000},
        '{32'h0003_8000, 16'h0004, 16'h0004}
    };

    // Mathematical round-half-to-even of x / 2^16, then clamp to the output range.
    function automatic logic [15:0] model(input logic [31:0] x, input bit sgn);
        longint v, q, r;
        v = sgn ? longint'($signed(x)) : longint'(x);
        q = v >>> 16;
        r = v - q * 65536;
        if (r > 32768 || (r == 32768 && (q & 1) != 0)) q = q + 1;
        if (sgn) begin
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
        end else begin
            if (q > 65535) q = 65535;
            if (q < 0) q = 0;
        end
        return q[15:0];
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input logic e, input logic r);
        @(negedge clk);
        din   = x;
        ena   = e;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h din=%h", tag, got, exp, din);
        end
    endtask

    initial begin
        logic [31:0] x;
        din   = '0;
        ena   = 1'b0;
        rst_n = 1'b0;

        // Two reset edges with garbage on din.
        applyStimulus(32'h1234_5678, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 1'b1, 1'b0);
        checkOutput("reset_s", dout_s, 16'h0000);
        checkOutput("reset_u", dout_u, 16'h0000);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(table_v[i].x, 1'b1, 1'b1);
            checkOutput($sformatf("dir%0d_s", i), dout_s, table_v[i].exp_s);
            checkOutput($sformatf("dir%0d_u", i), dout_u, table_v[i].exp_u);
        end

        // Clock enable low holds the last result while din moves.
        applyStimulus(32'h0001_8000, 1'b1, 1'b1);
        checkOutput("hold_load_s", dout_s, 16'h0002);
        applyStimulus(32'h0003_8000, 1'b0, 1'b1);
        checkOutput("hold1_s", dout_s, 16'h0002);
        checkOutput("hold1_u", dout_u, 16'h0002);
        applyStimulus(32'h8000_0000, 1'b0, 1'b1);
        checkOutput("hold2_s", dout_s, 16'h0002);
        checkOutput("hold2_u", dout_u, 16'h0002);

        // Reset wins over enable.
        applyStimulus(32'h0003_8000, 1'b1, 1'b0);
        checkOutput("rst_ena_s", dout_s, 16'h0000);
        checkOutput("rst_ena_u", dout_u, 16'h0000);

        // Exhaustive sweep of the top 32768 codes.
        for (int k = 0; k < 32768; k++) begin
            x = 32'hFFFF_8000 + 32'(k);
            applyStimulus(x, 1'b1, 1'b1);
            checkOutput("sweep_s", dout_s, model(x, 1'b1));
            checkOutput("sweep_u", dout_u, model(x, 1'b0));
        end

        for (int k = 0; k < 500; k++) begin
            x = $urandom;
            applyStimulus(x, 1'b1, 1'b1);
            checkOutput("rand_s", dout_s, model(x, 1'b1));
            checkOutput("rand_u", dout_u, model(x, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
